// File: rtl/ofm_pack_writer.sv
// OFM writeback: captures 16 activated PE outputs per pixel, packs them into four
// big-endian 32-bit words and writes them to the OFM BRAM in HWC order.
module ofm_pack_writer #(
  parameter int          OUT_W            = 56,
  parameter int          OUT_H            = 56,
  parameter int          NUM_FILTER_TILES = 2,
  parameter int          ADDR_W           = 20,
  parameter int unsigned BASE_ADDR        = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       valid,
  input  logic [127:0]      ofm_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              err_partial
);

  localparam int NUM_PIX  = OUT_W * OUT_H;
  localparam int PIX_W    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int TILE_W   = (NUM_FILTER_TILES > 1) ? $clog2(NUM_FILTER_TILES) : 1;
  localparam int CH_WORDS = 4 * NUM_FILTER_TILES;
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NUM_PIX - 1);
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_FILTER_TILES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [TILE_W-1:0]  tile_q, tile_d;
  logic               last_q, last_d;    // final frame of the map already seen
  logic [1:0]         count_q, count_d;  // buffered frames, including the one draining
  logic               head_q, head_d;
  logic [1:0]         widx_q, widx_d;    // word the head entry is emitting this cycle
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [31:0]        wr_data_q;
  logic               busy_q, done_q, done_d;

  logic [127:0]       buf_data_q [2];
  logic [ADDR_W-1:0]  buf_base_q [2];

  logic               emitting, pop, full, full_valid, capture, accept, tail;
  logic [ADDR_W-1:0]  new_base, hd_base;
  logic [127:0]       hd_data;

  // Channel 4w lands in the most significant byte of word w.
  function automatic logic [31:0] pack_word(input logic [127:0] d, input logic [1:0] w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) r[31-8*b -: 8] = d[32*int'(w) + 8*b +: 8];
    return r;
  endfunction

  assign emitting   = (count_q != 2'd0);
  assign pop        = emitting && (widx_q == 2'd3);
  assign full       = (count_q == 2'd2) && !pop;
  assign full_valid = (valid == 16'hFFFF);
  assign capture    = (state_q == S_RUN) && full_valid && !last_q;
  assign accept     = capture && !full;
  assign tail       = head_q ^ count_q[0];
  assign new_base   = ADDR_W'(BASE_ADDR) + ADDR_W'(pix_q) * ADDR_W'(CH_WORDS)
                    + ADDR_W'(tile_q) * ADDR_W'(4);

  // A frame landing in the slot that becomes head is forwarded straight to the
  // output registers so word 0 appears the cycle after capture.
  assign hd_data = (accept && tail == head_d) ? ofm_in   : buf_data_q[head_d];
  assign hd_base = (accept && tail == head_d) ? new_base : buf_base_q[head_d];

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    pix_d   = pix_q;
    tile_d  = tile_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pix_d   = '0;
          tile_d  = '0;
          last_d  = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (valid != 16'h0000 && !full_valid) err_d = 1'b1;
        // Counters advance even on a dropped frame so later addresses stay correct.
        if (capture) begin
          if (full) ovf_d = 1'b1;
          if (pix_q == LAST_PIX && tile_q == LAST_TILE) last_d = 1'b1;
          if (pix_q == LAST_PIX) begin
            pix_d  = '0;
            tile_d = (tile_q == LAST_TILE) ? '0 : tile_q + TILE_W'(1);
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end
        if (last_q && pop && count_q == 2'd1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    count_d = count_q - 2'(pop) + 2'(accept);
    head_d  = pop ? ~head_q : head_q;
    widx_d  = (emitting && !pop) ? widx_q + 2'd1 : 2'd0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pix_q     <= '0;
      tile_q    <= '0;
      last_q    <= 1'b0;
      count_q   <= 2'd0;
      head_q    <= 1'b0;
      widx_q    <= 2'd0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      tile_q  <= tile_d;
      last_q  <= last_d;
      count_q <= count_d;
      head_q  <= head_d;
      widx_q  <= widx_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      wr_en_q <= (count_d != 2'd0);
      if (count_d != 2'd0) begin
        wr_addr_q <= hd_base + ADDR_W'(widx_d);
        wr_data_q <= pack_word(hd_data, widx_d);
      end
      busy_q  <= (state_d == S_RUN);
      done_q  <= done_d;
    end
  end

  // NOTE: frame storage is not reset; count_q marks which entries are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_data_q[tail] <= ofm_in;
      buf_base_q[tail] <= new_base;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign err_partial = err_q;

endmodule
